// File: rtl/brick_tracker.sv
`default_nettype none
// ============================================================================
// Module      : brick_tracker
// Description : Per-level brick bookkeeping. Removes at most one brick per
//               video frame on collision reports, keeps the live brick count,
//               runs the level countdown timer and the level state machine
//               (IDLE / PLAY / CLEAR / TIMEOUT). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_tracker #(
  parameter int NUM_BRICKS   = 13,
  parameter int CLK_HZ       = 25_000_000,
  parameter int TIME_LIMIT_S = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_frame_tick,
  input  logic                  i_hit_valid,
  input  logic [3:0]            i_hit_idx,
  output logic                  o_hit_ack,
  output logic [NUM_BRICKS-1:0] o_brick_alive,
  output logic [3:0]            o_brick_count,
  output logic [3:0]            o_seconds_left,
  output logic                  o_playing,
  output logic                  o_level_clear,
  output logic                  o_time_up
);

  // A 1 Hz-or-slower clock still needs a 1-bit prescaler register
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0]         c_PRESC_TC   = PW'(CLK_HZ - 1);
  localparam logic [3:0]            c_NUM_BRICKS = 4'(NUM_BRICKS);
  localparam logic [3:0]            c_TIME_LIMIT = 4'(TIME_LIMIT_S);
  localparam logic [NUM_BRICKS-1:0] c_ALL_ALIVE  = {NUM_BRICKS{1'b1}};
  localparam logic [NUM_BRICKS-1:0] c_ONE_HOT0   = NUM_BRICKS'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_hit_lock;

  logic [15:0]           w_alive16;
  logic                  w_idx_ok;
  logic                  w_hit_ok;
  logic                  w_wrap;
  logic [NUM_BRICKS-1:0] w_clr_mask;

  // Zero-padded copy lets any 4-bit index be looked up without range issues
  assign w_alive16  = {{(16 - NUM_BRICKS){1'b0}}, o_brick_alive};
  assign w_idx_ok   = (i_hit_idx < c_NUM_BRICKS);
  assign w_hit_ok   = i_hit_valid & w_idx_ok & w_alive16[i_hit_idx] & ~r_hit_lock;
  assign w_wrap     = (r_presc == c_PRESC_TC);
  assign w_clr_mask = c_ONE_HOT0 << i_hit_idx;

  // Level state machine with brick state, timer and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_presc        <= '0;
      r_hit_lock     <= 1'b0;
      o_hit_ack      <= 1'b0;
      o_brick_alive  <= c_ALL_ALIVE;
      o_brick_count  <= c_NUM_BRICKS;
      o_seconds_left <= c_TIME_LIMIT;
      o_playing      <= 1'b0;
      o_level_clear  <= 1'b0;
      o_time_up      <= 1'b0;
    end else begin
      o_hit_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_brick_alive  <= c_ALL_ALIVE;
          o_brick_count  <= c_NUM_BRICKS;
          o_seconds_left <= c_TIME_LIMIT;
          if (i_start) begin
            r_state    <= ST_PLAY;
            r_presc    <= '0;
            r_hit_lock <= 1'b0;
            o_playing  <= 1'b1;
          end
        end

        ST_PLAY: begin
          // An accepted hit keeps the lock set even if frame_tick coincides
          if (w_hit_ok) begin
            o_brick_alive <= o_brick_alive & ~w_clr_mask;
            o_brick_count <= o_brick_count - 1'b1;
            o_hit_ack     <= 1'b1;
            r_hit_lock    <= 1'b1;
          end else if (i_frame_tick) begin
            r_hit_lock <= 1'b0;
          end

          if (w_wrap) begin
            r_presc <= '0;
            if (o_seconds_left != 4'd0) begin
              o_seconds_left <= o_seconds_left - 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end

          // Clearing the last brick takes priority over a simultaneous timeout
          if (w_hit_ok && (o_brick_count == 4'd1)) begin
            r_state       <= ST_CLEAR;
            o_playing     <= 1'b0;
            o_level_clear <= 1'b1;
          end else if (w_wrap && (o_seconds_left == 4'd1)) begin
            r_state   <= ST_TIMEOUT;
            o_playing <= 1'b0;
            o_time_up <= 1'b1;
          end
        end

        ST_CLEAR, ST_TIMEOUT: begin
          if (i_start) begin
            r_state        <= ST_PLAY;
            r_presc        <= '0;
            r_hit_lock     <= 1'b0;
            o_brick_alive  <= c_ALL_ALIVE;
            o_brick_count  <= c_NUM_BRICKS;
            o_seconds_left <= c_TIME_LIMIT;
            o_playing      <= 1'b1;
            o_level_clear  <= 1'b0;
            o_time_up      <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
